ram_dp_sync: RTL and testbench

//  Simple dual-port RAM: 1 write port, 1 registered read port, per-byte write enables.

---
 rtl/ram_dp_sync_if.sv | 38 +++
 rtl/ram_dp_sync.sv | 127 ++++++++++++
 tb/tb_ram_dp_sync.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_sync_if.sv
// Write/read port bundle for ram_dp_sync. The parity pins exist only when
// RAM_PARITY_EN is defined.
interface ram_dp_sync_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic                 init_busy;
  logic                 wr_en;
  logic [DEPTH-1:0]     wr_addr;
  logic [WIDTH/8-1:0]   wr_be;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_en;
  logic [DEPTH-1:0]     rd_addr;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
`ifdef RAM_PARITY_EN
  logic                 rd_perr;
  logic                 wr_perr_inj;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, wr_perr_inj, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid, rd_perr
  );
  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, wr_perr_inj, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid, rd_perr
  );
`else
  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid
  );
  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid
  );
`endif
endinterface

// File: rtl/ram_dp_sync.sv
// Simple dual-port RAM, byte-lane writes, registered write-first read, and a
// zero-fill sweep after reset. Optional per-lane even parity: RAM_PARITY_EN.
module ram_dp_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_dp_sync_if.slave  bus
);
  localparam int BE_W    = WIDTH / 8;
  localparam int ENTRIES = 2 ** DEPTH;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t             state_reg, state_next;
  logic [DEPTH-1:0]   init_cnt_reg, init_cnt_next;
  logic               init_phase;
  logic               mem_init;
  logic               wr_fire;
  logic               rd_fire;
  logic               same_addr;
  logic [DEPTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   rd_data_reg, rd_data_next;
  logic               rd_valid_reg;
`ifdef RAM_PARITY_EN
  logic [BE_W-1:0]    perr_lane;
  logic               rd_perr_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    init_phase    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_phase    = 1'b1;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == {DEPTH{1'b1}}) begin
          state_next = ST_READY;
        end
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // The sweep borrows the write port, so user traffic is locked out meanwhile.
  assign mem_init  = init_phase && !rst;
  assign wr_fire   = (state_reg == ST_READY) && !rst && bus.wr_en;
  assign rd_fire   = (state_reg == ST_READY) && bus.rd_en;
  assign same_addr = wr_fire && rd_fire && (bus.wr_addr == bus.rd_addr);
  assign mem_addr  = mem_init ? init_cnt_reg : bus.wr_addr;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] mem_lane [ENTRIES];
      logic [7:0] wr_lane;
      logic       lane_we;
      logic       lane_fwd;
      assign wr_lane  = bus.wr_data[8*gi +: 8];
      assign lane_we  = mem_init || (wr_fire && bus.wr_be[gi]);
      assign lane_fwd = same_addr && bus.wr_be[gi];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem_lane[mem_addr] <= mem_init ? 8'h00 : wr_lane;
        end
      end

      assign rd_data_next[8*gi +: 8] = lane_fwd ? wr_lane : mem_lane[bus.rd_addr];

`ifdef RAM_PARITY_EN
      logic par_lane [ENTRIES];
      logic wr_par;
      logic rd_par;
      assign wr_par = mem_init ? 1'b0 : (^wr_lane ^ bus.wr_perr_inj);

      always_ff @(posedge clk) begin
        if (lane_we) begin
          par_lane[mem_addr] <= wr_par;
        end
      end

      assign rd_par        = lane_fwd ? wr_par : par_lane[bus.rd_addr];
      assign perr_lane[gi] = rd_par ^ (^rd_data_next[8*gi +: 8]);
`endif
    end
  endgenerate

  // Reset wins over a read issued the same cycle, dropping it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
`ifdef RAM_PARITY_EN
      rd_perr_reg  <= 1'b0;
`endif
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) begin
        rd_data_reg <= rd_data_next;
      end
`ifdef RAM_PARITY_EN
      rd_perr_reg  <= rd_fire && (|perr_lane);
`endif
    end
  end

  assign bus.init_busy = (state_reg == ST_INIT);
  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = rd_valid_reg;
`ifdef RAM_PARITY_EN
  assign bus.rd_perr   = rd_perr_reg;
`endif
endmodule

// File: tb/tb_ram_dp_sync.sv
// Directed scoreboard bench for ram_dp_sync (WIDTH=16, DEPTH=4): stimulus
// pushes expected reads, a monitor checks each rd_valid against the queue.
module tb_ram_dp_sync;
  localparam int W = 16;
  localparam int D = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         p;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  exp_t q[$];

  ram_dp_sync_if #(.WIDTH(W), .DEPTH(D)) bus ();

  ram_dp_sync #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every rd_valid must match the oldest expectation, one cycle after issue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.rd_valid === 1'b1) begin
      valid_cnt++;
      tests++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid cycle=%0d rd_data=%h required=no read", cyc, bus.rd_data);
      end else begin
        e = q.pop_front();
        if (bus.rd_data !== e.d || cyc != e.cyc) begin
          errors++;
          $display("FAIL read_data cycle=%0d actual=%h required=%h at cycle %0d", cyc, bus.rd_data, e.d, e.cyc);
        end else begin
          $display("[TB] read ok cycle=%0d data=%h", cyc, bus.rd_data);
        end
`ifdef RAM_PARITY_EN
        tests++;
        if (bus.rd_perr !== e.p) begin
          errors++;
          $display("FAIL read_perr cycle=%0d actual=%b required=%b", cyc, bus.rd_perr, e.p);
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("[TB] %s ok value=%h", name, act);
    end
  endtask

  task automatic drive(input logic we, input logic [D-1:0] wa, input logic [1:0] be,
                       input logic [W-1:0] wd, input logic inj, input logic re,
                       input logic [D-1:0] ra, input logic [W-1:0] exp_d, input logic exp_p);
    exp_t e;
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_be   = be;
    bus.wr_data = wd;
`ifdef RAM_PARITY_EN
    bus.wr_perr_inj = inj;
`endif
    bus.rd_en   = re;
    bus.rd_addr = ra;
    if (re) begin
      e.d = exp_d;
      e.p = exp_p;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, 2'b00, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [D-1:0] a, input logic [1:0] be, input logic [W-1:0] d);
    drive(1'b1, a, be, d, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [D-1:0] a, input logic [W-1:0] exp_d);
    drive(1'b0, '0, 2'b00, '0, 1'b0, 1'b1, a, exp_d, 1'b0);
  endtask

  // Hold rst released for the 16 sweep cycles while hammering the ports.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_busy"}, {15'd0, bus.init_busy}, 16'd1);
      @(negedge clk);
    end
    check({tag, "_done"}, {15'd0, bus.init_busy}, 16'd0);
  endtask

  initial begin
    int vc0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
`ifdef RAM_PARITY_EN
    bus.wr_perr_inj = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
    check("reset_rd_data", bus.rd_data, 16'h0000);

    // Release reset with ports active; sweep must ignore them.
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_be = 2'b11; bus.wr_data = 16'hFFFF;
    bus.rd_en = 1'b1; bus.rd_addr = 4'd0;
    check_sweep("init");
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;

    for (int i = 0; i < 16; i++) rd(i[D-1:0], 16'h0000);
    idle();

    wr(4'd3, 2'b11, 16'hBEEF);
    rd(4'd3, 16'hBEEF);
    wr(4'd3, 2'b01, 16'h1234);
    rd(4'd3, 16'hBE34);
    idle();
    idle();
    check("hold_rd_data", bus.rd_data, 16'hBE34);
    check("hold_rd_valid", {15'd0, bus.rd_valid}, 16'd0);

    // Write-first forwarding on a partial lane write.
    wr(4'd5, 2'b11, 16'h0011);
    drive(1'b1, 4'd5, 2'b10, 16'hA5A5, 1'b0, 1'b1, 4'd5, 16'hA511, 1'b0);
    rd(4'd5, 16'hA511);
    wr(4'd5, 2'b00, 16'hFFFF);
    rd(4'd5, 16'hA511);
    // Different addresses in the same cycle are independent.
    drive(1'b1, 4'd6, 2'b11, 16'h6666, 1'b0, 1'b1, 4'd3, 16'hBE34, 1'b0);
    rd(4'd6, 16'h6666);
    idle();

    for (int i = 0; i < 16; i++) wr(i[D-1:0], 2'b11, 16'(i * 16'h0101));
    idle();
    vc0 = valid_cnt;
    for (int i = 0; i < 16; i++) rd(i[D-1:0], 16'(i * 16'h0101));
    idle();
    idle();
    check("burst_valid_count", 16'(valid_cnt - vc0), 16'd16);

`ifdef RAM_PARITY_EN
    drive(1'b1, 4'd7, 2'b11, 16'h00FF, 1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 2'b00, '0, 1'b0, 1'b1, 4'd7, 16'h00FF, 1'b1);
    drive(1'b1, 4'd7, 2'b11, 16'h00FF, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 2'b00, '0, 1'b0, 1'b1, 4'd7, 16'h00FF, 1'b0);
    // Forwarded lane carries the freshly injected parity.
    drive(1'b1, 4'd8, 2'b01, 16'h0012, 1'b1, 1'b1, 4'd8, 16'h0812, 1'b1);
    idle();
`endif

    // Reset on the same cycle as a read: the read is dropped.
    @(negedge clk);
    rst = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = 4'd3;
    @(negedge clk);
    check("midrst_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
    check("midrst_rd_data", bus.rd_data, 16'h0000);
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_be = 2'b11; bus.wr_data = 16'hFFFF;
    check_sweep("midrst");
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    rd(4'd3, 16'h0000);
    rd(4'd0, 16'h0000);
    rd(4'd15, 16'h0000);
    idle();
    idle();
    idle();

    tests++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
